// File: rtl/ltc_set_ctrl_if.sv
// ltc_set_ctrl_if: set-button, frame timing and increment-pulse signals of the LTC time-set controller
interface ltc_set_ctrl_if;
    logic btn_hrs;
    logic btn_min;
    logic btn_sec;
    logic frame_start;
    logic en;
    logic inc_hrs;
    logic inc_min;
    logic inc_sec;
    logic busy;
    modport master (
        output btn_hrs, btn_min, btn_sec, frame_start, en,
        input  inc_hrs, inc_min, inc_sec, busy
    );
    modport slave (
        input  btn_hrs, btn_min, btn_sec, frame_start, en,
        output inc_hrs, inc_min, inc_sec, busy
    );
endinterface

// File: rtl/ltc_set_ctrl.sv
// ltc_set_ctrl: debounced set buttons with frame-counted auto-repeat, one increment pulse per frame boundary
module ltc_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 25,
    parameter int REPEAT_PERIOD   = 5
) (
    input logic           clk,
    input logic           reset_n,
    ltc_set_ctrl_if.slave bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int FMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;
    logic [2:0]    raw, s1_q, s2_q, db_q, db_d, hit, rise, fall, set;
    logic [2:0]    issued, pend_q, pend_d, inc_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [FW-1:0] fc_q  [3];
    logic [FW-1:0] fc_d  [3];
    st_t           st_q  [3];
    st_t           st_d  [3];
    logic          busy_q, busy_d, go;
    assign raw = {bus.btn_hrs, bus.btn_min, bus.btn_sec};
    assign go  = bus.frame_start & bus.en;
    always_comb begin
        hit  = '0;
        rise = '0;
        fall = '0;
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            hit[i]   = (s2_q[i] != db_q[i]) && (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
            cnt_d[i] = (s2_q[i] == db_q[i] || hit[i]) ? '0 : cnt_q[i] + 1'b1;
            db_d[i]  = hit[i] ? s2_q[i] : db_q[i];
            rise[i]  = hit[i] & s2_q[i];
            fall[i]  = hit[i] & ~s2_q[i];
        end
    end
    // frame counting runs regardless of en; only issuing is gated
    always_comb begin
        set = '0;
        for (int i = 0; i < 3; i++) begin
            st_d[i] = st_q[i];
            fc_d[i] = fc_q[i];
            if (fall[i]) begin
                st_d[i] = IDLE;
                fc_d[i] = '0;
            end else begin
                case (st_q[i])
                    IDLE: if (rise[i]) begin
                        set[i]  = 1'b1;
                        fc_d[i] = '0;
                        st_d[i] = DELAY;
                    end
                    DELAY: if (bus.frame_start) begin
                        if (fc_q[i] == FW'(REPEAT_DELAY - 1)) begin
                            set[i]  = 1'b1;
                            fc_d[i] = '0;
                            st_d[i] = REPEAT;
                        end else begin
                            fc_d[i] = fc_q[i] + 1'b1;
                        end
                    end
                    REPEAT: if (bus.frame_start) begin
                        if (fc_q[i] == FW'(REPEAT_PERIOD - 1)) begin
                            set[i]  = 1'b1;
                            fc_d[i] = '0;
                        end else begin
                            fc_d[i] = fc_q[i] + 1'b1;
                        end
                    end
                    default: st_d[i] = IDLE;
                endcase
            end
        end
    end
    always_comb begin
        issued = !go      ? 3'b000 :
                 pend_q[2] ? 3'b100 :
                 pend_q[1] ? 3'b010 :
                 pend_q[0] ? 3'b001 : 3'b000;
        pend_d = (pend_q & ~issued) | set;
        busy_d = |pend_d;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            pend_q <= '0;
            inc_q  <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                fc_q[i]  <= '0;
                st_q[i]  <= IDLE;
            end
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            db_q   <= db_d;
            pend_q <= pend_d;
            inc_q  <= issued;
            busy_q <= busy_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                fc_q[i]  <= fc_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end
    assign bus.inc_hrs = inc_q[2];
    assign bus.inc_min = inc_q[1];
    assign bus.inc_sec = inc_q[0];
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ltc_set_ctrl.sv
// tb_ltc_set_ctrl: directed stimulus with an expected-pulse queue checked by an independent monitor
module tb_ltc_set_ctrl;
    typedef struct {
        int         f;
        logic [2:0] c;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   nfs = 0;
    int   k;
    bit   fs_hold = 1'b0;
    bit   seen;
    ltc_set_ctrl_if bus ();
    ltc_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic push(input int f, input logic [2:0] c);
        q.push_back('{f, c});
    endtask
    task automatic wait_fs(input int n);
        repeat (n) @(negedge bus.frame_start);
        @(negedge clk);
    endtask
    // one-cycle frame_start every 10 clk; nfs counts the pulses sampled so far
    initial begin
        bus.frame_start = 1'b0;
        forever begin
            repeat (9) @(posedge clk);
            if (!fs_hold) begin
                #1 bus.frame_start = 1'b1;
                @(posedge clk);
                #1 bus.frame_start = 1'b0;
                nfs++;
            end else begin
                @(posedge clk);
            end
        end
    end
    logic [2:0] inc;
    exp_t       e;
    always @(negedge clk) begin
        inc = {bus.inc_hrs, bus.inc_min, bus.inc_sec};
        if (inc != 3'b000) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse: got inc=%b at frame %0d expected none", inc, nfs);
            end else begin
                e = q.pop_front();
                chk("pulse_code", int'(inc), int'(e.c));
                chk("pulse_frame", nfs, e.f);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        bus.btn_hrs = 1'b0;
        bus.btn_min = 1'b0;
        bus.btn_sec = 1'b0;
        bus.en      = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_inc", int'({bus.inc_hrs, bus.inc_min, bus.inc_sec}), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        wait_fs(2);
        bus.btn_min = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_min = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= bus.busy;
        end
        chk("glitch_busy", int'(seen), 0);
        wait_fs(1);
        k = nfs;
        bus.btn_sec = 1'b1;
        push(k + 1, 3'b001);
        push(k + 4, 3'b001);
        push(k + 6, 3'b001);
        push(k + 8, 3'b001);
        wait_fs(8);
        bus.btn_sec = 1'b0;
        wait_fs(3);
        k = nfs;
        bus.btn_hrs = 1'b1;
        bus.btn_sec = 1'b1;
        push(k + 1, 3'b100);
        push(k + 2, 3'b001);
        repeat (8) @(negedge clk);
        chk("dual_busy", int'(bus.busy), 1);
        bus.btn_hrs = 1'b0;
        bus.btn_sec = 1'b0;
        wait_fs(4);
        bus.en = 1'b0;
        k = nfs;
        bus.btn_min = 1'b1;
        repeat (6) @(negedge clk);
        bus.btn_min = 1'b0;
        wait_fs(2);
        chk("en_low_busy", int'(bus.busy), 1);
        bus.en = 1'b1;
        push(k + 3, 3'b010);
        wait_fs(1);
        chk("en_high_busy", int'(bus.busy), 0);
        wait_fs(2);
        k = nfs;
        bus.btn_min = 1'b1;
        push(k + 1, 3'b010);
        push(k + 4, 3'b010);
        wait_fs(5);
        chk("hold_busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_inc", int'({bus.inc_hrs, bus.inc_min, bus.inc_sec}), 0);
        chk("midreset_busy", int'(bus.busy), 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        push(k + 7, 3'b010);
        wait_fs(2);
        bus.btn_min = 1'b0;
        wait_fs(3);
        k = nfs;
        fs_hold = 1'b1;
        repeat (2) begin
            bus.btn_sec = 1'b1;
            repeat (5) @(negedge clk);
            bus.btn_sec = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("collapse_busy", int'(bus.busy), 1);
        fs_hold = 1'b0;
        push(k + 1, 3'b001);
        wait_fs(2);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
